// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage RISC-V pipeline.
// Holds the EX/MEM pipeline register, drives the data-memory req/ack bus,
// aligns store lanes, extracts/sign-extends load data and produces the
// registered MEM/WB outputs. An unanswered request is aborted after
// ACK_TIMEOUT request cycles and flagged on the sticky MEM_bus_err.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned half/word
// accesses instead of silently ignoring the low address bits).
module mem_stage #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_alu_res,
    input  logic [31:0] EX_mem_din,
    input  logic        EX_vld,
    input  logic        EX_rd_mem,
    input  logic        EX_wr_mem,
    input  logic [1:0]  EX_size,
    input  logic        EX_unsigned,
    input  logic [4:0]  EX_dest_reg,
    input  logic        EX_reg_wr,
    output logic        proc2Dmem_req,
    output logic        proc2Dmem_we,
    output logic [31:0] proc2Dmem_addr,
    output logic [31:0] proc2Dmem_data,
    output logic [3:0]  proc2Dmem_be,
    input  logic        Dmem2proc_ack,
    input  logic [31:0] Dmem2proc_data,
    output logic [31:0] MEM_data,
    output logic        MEM_stall,
    output logic [31:0] MEM_WB_result,
    output logic [4:0]  MEM_WB_dest_reg,
    output logic        MEM_WB_reg_wr,
    output logic        MEM_WB_vld,
    output logic        MEM_bus_err,
    output logic        MEM_misalign
);

    typedef enum logic [0:0] {RUN = 1'b0, WAIT = 1'b1} state_e;

    // Counter value seen in the last request cycle before the abort.
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    // Byte enables for a store of the given size at the given low address bits.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated into every lane it may occupy.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] din);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{din[7:0]}};
            2'b01:   d = {2{din[15:0]}};
            default: d = din;
        endcase
        return d;
    endfunction

    // Select the addressed lane of the read word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                                 input logic [1:0] lo, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        if (lo[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (size)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    // A half must sit on an even address, a word (size 10/11) on a multiple of 4.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = lo[0];
            default: m = (lo != 2'b00);
        endcase
        return m;
    endfunction
`endif

    state_e      state_r;
    state_e      state_next_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_cur_s;
    logic [7:0]  cnt_next_s;

    logic        vld_r;
    logic        rd_r;
    logic        wr_r;
    logic [1:0]  size_r;
    logic        uns_r;
    logic [4:0]  dest_r;
    logic        reg_wr_r;
    logic [31:0] alu_r;
    logic [31:0] din_r;

    logic        mem_op_s;
    logic        misalign_s;
    logic        req_s;
    logic        timeout_s;
    logic        stall_s;
    logic        misalign_r;

    // Request/stall/timeout decisions and FSM next state for the op in the stage.
    always_comb begin
        mem_op_s = vld_r && (rd_r || wr_r);
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_s = mem_op_s && is_misaligned(size_r, alu_r[1:0]);
`else
        misalign_s = 1'b0;
`endif
        req_s = mem_op_s && !misalign_s;
        // The counter only carries meaning while waiting; a fresh request starts at zero.
        if (state_r == WAIT) begin
            cnt_cur_s = cnt_r;
        end else begin
            cnt_cur_s = 8'd0;
        end
        timeout_s = req_s && !Dmem2proc_ack && (cnt_cur_s == TIMEOUT_LAST);
        stall_s   = req_s && !Dmem2proc_ack && !timeout_s;
        if (stall_s) begin
            state_next_s = WAIT;
            cnt_next_s   = cnt_cur_s + 8'd1;
        end else begin
            state_next_s = RUN;
            cnt_next_s   = 8'd0;
        end
    end

    // FSM state and ack-timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // EX/MEM pipeline register: load when not stalled, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r    <= 1'b0;
            rd_r     <= 1'b0;
            wr_r     <= 1'b0;
            size_r   <= 2'b00;
            uns_r    <= 1'b0;
            dest_r   <= 5'd0;
            reg_wr_r <= 1'b0;
            alu_r    <= 32'h0000_0000;
            din_r    <= 32'h0000_0000;
        end else if (!stall_s) begin
            vld_r    <= EX_vld;
            rd_r     <= EX_rd_mem;
            wr_r     <= EX_wr_mem;
            size_r   <= EX_size;
            uns_r    <= EX_unsigned;
            dest_r   <= EX_dest_reg;
            reg_wr_r <= EX_reg_wr;
            alu_r    <= EX_alu_res;
            din_r    <= EX_mem_din;
        end else begin
            vld_r    <= vld_r;
        end
    end

    // MEM/WB register: retire the op on a non-stalled edge, insert a bubble while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            MEM_WB_result   <= 32'h0000_0000;
            MEM_WB_dest_reg <= 5'd0;
            MEM_WB_reg_wr   <= 1'b0;
            MEM_WB_vld      <= 1'b0;
        end else if (stall_s) begin
            MEM_WB_reg_wr   <= 1'b0;
            MEM_WB_vld      <= 1'b0;
        end else begin
            MEM_WB_vld      <= vld_r && !timeout_s && !misalign_s;
            MEM_WB_reg_wr   <= vld_r && reg_wr_r && !wr_r && !timeout_s && !misalign_s;
            MEM_WB_dest_reg <= dest_r;
            MEM_WB_result   <= (rd_r && !wr_r) ?
                               load_extract(size_r, uns_r, alu_r[1:0], Dmem2proc_data) : alu_r;
        end
    end

    // Sticky bus-error flag and one-cycle misalignment pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            MEM_bus_err <= 1'b0;
            misalign_r  <= 1'b0;
        end else begin
            MEM_bus_err <= MEM_bus_err || timeout_s;
            misalign_r  <= misalign_s;
        end
    end

    assign MEM_misalign   = misalign_r;
    assign MEM_stall      = stall_s;
    assign MEM_data       = alu_r;
    assign proc2Dmem_req  = req_s;
    assign proc2Dmem_we   = req_s && wr_r;
    assign proc2Dmem_addr = req_s ? {alu_r[31:2], 2'b00} : 32'h0000_0000;
    assign proc2Dmem_data = req_s ? store_data(size_r, din_r) : 32'h0000_0000;
    assign proc2Dmem_be   = req_s ? store_be(size_r, alu_r[1:0]) : 4'b0000;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed test-plan scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_mem_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] EX_alu_res, EX_mem_din, Dmem2proc_data;
    logic        EX_vld, EX_rd_mem, EX_wr_mem, EX_unsigned, EX_reg_wr, Dmem2proc_ack;
    logic [1:0]  EX_size;
    logic [4:0]  EX_dest_reg;
    logic        proc2Dmem_req, proc2Dmem_we, MEM_stall, MEM_WB_reg_wr, MEM_WB_vld;
    logic        MEM_bus_err, MEM_misalign;
    logic [31:0] proc2Dmem_addr, proc2Dmem_data, MEM_data, MEM_WB_result;
    logic [3:0]  proc2Dmem_be;
    logic [4:0]  MEM_WB_dest_reg;

    mem_stage #(.ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .EX_alu_res(EX_alu_res), .EX_mem_din(EX_mem_din), .EX_vld(EX_vld),
        .EX_rd_mem(EX_rd_mem), .EX_wr_mem(EX_wr_mem), .EX_size(EX_size),
        .EX_unsigned(EX_unsigned), .EX_dest_reg(EX_dest_reg), .EX_reg_wr(EX_reg_wr),
        .proc2Dmem_req(proc2Dmem_req), .proc2Dmem_we(proc2Dmem_we),
        .proc2Dmem_addr(proc2Dmem_addr), .proc2Dmem_data(proc2Dmem_data),
        .proc2Dmem_be(proc2Dmem_be), .Dmem2proc_ack(Dmem2proc_ack),
        .Dmem2proc_data(Dmem2proc_data), .MEM_data(MEM_data), .MEM_stall(MEM_stall),
        .MEM_WB_result(MEM_WB_result), .MEM_WB_dest_reg(MEM_WB_dest_reg),
        .MEM_WB_reg_wr(MEM_WB_reg_wr), .MEM_WB_vld(MEM_WB_vld),
        .MEM_bus_err(MEM_bus_err), .MEM_misalign(MEM_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld, rd, wr, uns, regwr;
        logic [1:0]  size;
        logic [4:0]  dest;
        logic [31:0] alu, din, rdata;
        int          lat;   // request cycles before ack; large = never
    } op_t;

    op_t         q[$];
    op_t         m;         // op currently held in the stage (model view)
    int          m_wait;    // request cycles already spent without ack
    bit          model_ok = 1'b0;
    logic        exp_wb_vld, exp_wb_rw, exp_err, exp_mis;
    logic [31:0] exp_wb_res;
    logic [4:0]  exp_wb_dest;
    int          checks = 0, failures = 0;

    logic        obs_req, obs_we, obs_stall;
    logic [31:0] obs_addr, obs_data;
    logic [3:0]  obs_be;
    int          n_stall, n_req, n_mis;
    logic [31:0] ret_res[$];
    logic        ret_rw[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk_op(logic vld, logic rd, logic wr, logic [1:0] size, logic uns,
                                  logic [31:0] alu, logic [31:0] din, logic [31:0] rdata,
                                  int lat, logic [4:0] dest, logic regwr);
        op_t o;
        o.vld = vld; o.rd = rd; o.wr = wr; o.size = size; o.uns = uns; o.alu = alu;
        o.din = din; o.rdata = rdata; o.lat = lat; o.dest = dest; o.regwr = regwr;
        return o;
    endfunction

    function automatic logic [31:0] ref_load(logic [1:0] size, logic uns, logic [1:0] lo,
                                             logic [31:0] w);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (w >> (8 * lo)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (w >> (16 * lo[1])) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic ref_mis(op_t o);
`ifdef MEM_MISALIGN_TRAP_EN
        return o.vld && (o.rd || o.wr) &&
               ((o.size == 2'd1 && o.alu[0]) || (o.size[1] && o.alu[1:0] != 2'd0));
`else
        return 1'b0;
`endif
    endfunction

    task automatic clear_logs();
        n_stall = 0; n_req = 0; n_mis = 0;
        ret_res.delete(); ret_rw.delete();
    endtask

    // One clock cycle: drive EX and bus inputs, compare at negedge, advance model at posedge.
    task automatic step();
        op_t         head;
        logic        mis_l, req_l, ack_l, stall_l, tmo_l;
        logic [31:0] be_l, data_l;
        if (q.size() > 0) head = q[0];
        else head = mk_op(1'b0, 1'($urandom), 1'b0, 2'($urandom), 1'($urandom), $urandom,
                          $urandom, $urandom, 0, 5'($urandom), 1'($urandom));
        EX_vld = head.vld; EX_rd_mem = head.rd; EX_wr_mem = head.wr; EX_size = head.size;
        EX_unsigned = head.uns; EX_alu_res = head.alu; EX_mem_din = head.din;
        EX_dest_reg = head.dest; EX_reg_wr = head.regwr;
        mis_l = ref_mis(m);
        req_l = m.vld && (m.rd || m.wr) && !mis_l;
        ack_l = req_l ? (m_wait == m.lat) : 1'($urandom);
        Dmem2proc_ack  = rst ? 1'b0 : ack_l;
        Dmem2proc_data = (req_l && ack_l) ? m.rdata : $urandom;
        stall_l = !rst && req_l && !ack_l && (m_wait + 1 < TMO);
        tmo_l   = req_l && !ack_l && (m_wait + 1 >= TMO);
        if (m.size == 2'd0) be_l = 32'h1 << m.alu[1:0];
        else if (m.size == 2'd1) be_l = 32'h3 << (2 * m.alu[1]);
        else be_l = 32'hF;
        if (m.size == 2'd0) data_l = 32'(m.din[7:0]) * 32'h0101_0101;
        else if (m.size == 2'd1) data_l = 32'(m.din[15:0]) * 32'h0001_0001;
        else data_l = m.din;
        @(negedge clk);
        obs_req = proc2Dmem_req; obs_we = proc2Dmem_we; obs_addr = proc2Dmem_addr;
        obs_be = proc2Dmem_be; obs_data = proc2Dmem_data; obs_stall = MEM_stall;
        if (proc2Dmem_req === 1'b1) n_req++;
        if (MEM_stall === 1'b1) n_stall++;
        if (MEM_misalign === 1'b1) n_mis++;
        if (MEM_WB_vld === 1'b1) begin
            ret_res.push_back(MEM_WB_result);
            ret_rw.push_back(MEM_WB_reg_wr);
        end
        if (model_ok) begin
            chk("req", 32'(proc2Dmem_req), 32'(req_l));
            if (!rst) chk("stall", 32'(MEM_stall), 32'(stall_l));
            if (req_l) begin
                chk("we", 32'(proc2Dmem_we), 32'(m.wr));
                chk("addr", proc2Dmem_addr, m.alu & 32'hFFFF_FFFC);
                chk("be", 32'(proc2Dmem_be), be_l);
                if (m.wr) chk("wdata", proc2Dmem_data, data_l);
            end
            chk("wb_vld", 32'(MEM_WB_vld), 32'(exp_wb_vld));
            chk("wb_reg_wr", 32'(MEM_WB_reg_wr), 32'(exp_wb_rw));
            if (exp_wb_vld) begin
                chk("wb_result", MEM_WB_result, exp_wb_res);
                chk("wb_dest", 32'(MEM_WB_dest_reg), 32'(exp_wb_dest));
            end
            chk("mem_data", MEM_data, m.alu);
            chk("bus_err", 32'(MEM_bus_err), 32'(exp_err));
            chk("misalign", 32'(MEM_misalign), 32'(exp_mis));
        end
        @(posedge clk);
        if (rst) begin
            m = mk_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 0, 5'd0, 1'b0);
            m_wait = 0; exp_wb_vld = 1'b0; exp_wb_rw = 1'b0; exp_wb_res = 32'd0;
            exp_wb_dest = 5'd0; exp_err = 1'b0; exp_mis = 1'b0; model_ok = 1'b1;
        end else if (stall_l) begin
            m_wait++; exp_wb_vld = 1'b0; exp_wb_rw = 1'b0; exp_mis = 1'b0;
        end else begin
            exp_wb_vld  = m.vld && !tmo_l && !mis_l;
            exp_wb_rw   = m.vld && m.regwr && !m.wr && !tmo_l && !mis_l;
            exp_wb_res  = (m.vld && m.rd && !m.wr) ? ref_load(m.size, m.uns, m.alu[1:0], m.rdata)
                                                   : m.alu;
            exp_wb_dest = m.dest;
            exp_err     = exp_err || tmo_l;
            exp_mis     = mis_l;
            m = head; m_wait = 0;
            if (q.size() > 0) void'(q.pop_front());
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        Dmem2proc_ack = 1'b0; Dmem2proc_data = 32'd0;
        step(); step();
        chk("rst_wb_vld", 32'(MEM_WB_vld), 32'd0);
        chk("rst_wb_res", MEM_WB_result, 32'd0);
        chk("rst_wb_rw", 32'(MEM_WB_reg_wr), 32'd0);
        chk("rst_mem_data", MEM_data, 32'd0);
        chk("rst_req", 32'(proc2Dmem_req), 32'd0);
        chk("rst_addr", proc2Dmem_addr, 32'd0);
        chk("rst_be", 32'(proc2Dmem_be), 32'd0);
        chk("rst_err", 32'(MEM_bus_err), 32'd0);
        rst = 1'b0;

        // Store byte to 0x1003, ack in the first request cycle.
        clear_logs();
        q.push_back(mk_op(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h1003, 32'hAB, 32'd0, 0, 5'd3, 1'b1));
        step(); step();
        chk("sb_req", 32'(obs_req), 32'd1);
        chk("sb_we", 32'(obs_we), 32'd1);
        chk("sb_addr", obs_addr, 32'h1000);
        chk("sb_be", 32'(obs_be), 32'b1000);
        chk("sb_data", obs_data, 32'hABAB_ABAB);
        chk("sb_stall", 32'(obs_stall), 32'd0);
        step(); step();
        chk("sb_retired", 32'(ret_rw.size()), 32'd1);
        chk("sb_reg_wr", 32'(ret_rw[0]), 32'd0);

        // Signed half load acked after 3 cycles, with an ADD queued right behind it.
        clear_logs();
        q.push_back(mk_op(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h2002, 32'd0, 32'h8001_1234, 3, 5'd5, 1'b1));
        q.push_back(mk_op(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h55, 32'd0, 32'd0, 0, 5'd6, 1'b1));
        repeat (8) step();
        chk("lh_stalls", 32'(n_stall), 32'd3);
        chk("lh_retired", 32'(ret_res.size()), 32'd2);
        chk("lh_result", ret_res[0], 32'hFFFF_8001);
        chk("lh_reg_wr", 32'(ret_rw[0]), 32'd1);
        chk("add_result", ret_res[1], 32'h55);

        // Unsigned byte load from lane 1.
        clear_logs();
        q.push_back(mk_op(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h2001, 32'd0, 32'h0000_F000, 1, 5'd9, 1'b1));
        repeat (5) step();
        chk("lbu_result", ret_res[0], 32'h0000_00F0);
        chk("lbu_stalls", 32'(n_stall), 32'd1);

        // Word load at a misaligned address.
        clear_logs();
        q.push_back(mk_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h3002, 32'd0, 32'h1234_5678, 0, 5'd4, 1'b1));
        step(); step();
`ifdef MEM_MISALIGN_TRAP_EN
        step(); step();
        chk("mis_req", 32'(n_req), 32'd0);
        chk("mis_pulse", 32'(n_mis), 32'd1);
        chk("mis_retired", 32'(ret_res.size()), 32'd0);
`else
        chk("mis_addr", obs_addr, 32'h3000);
        chk("mis_be", 32'(obs_be), 32'hF);
        step(); step();
        chk("mis_pulse", 32'(n_mis), 32'd0);
        chk("mis_result", ret_res[0], 32'h1234_5678);
`endif

        // Load that is never acked: aborts after TMO request cycles.
        clear_logs();
        q.push_back(mk_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h4000, 32'd0, 32'd0, 1000, 5'd8, 1'b1));
        repeat (8) step();
        chk("tmo_req_cycles", 32'(n_req), 32'(TMO));
        chk("tmo_err", 32'(MEM_bus_err), 32'd1);
        chk("tmo_retired", 32'(ret_res.size()), 32'd0);
        q.push_back(mk_op(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h77, 32'd0, 32'd0, 0, 5'd2, 1'b1));
        repeat (3) step();
        chk("tmo_err_sticky", 32'(MEM_bus_err), 32'd1);

        // Reset in the middle of an outstanding access.
        clear_logs();
        q.push_back(mk_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h5000, 32'd0, 32'd0, 1000, 5'd1, 1'b1));
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_req", 32'(proc2Dmem_req), 32'd0);
        chk("rstmid_err", 32'(MEM_bus_err), 32'd0);
        repeat (3) step();
        chk("rstmid_req_cycles", 32'(n_req), 32'd2);
        chk("rstmid_retired", 32'(ret_res.size()), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if (q.size() < 2) begin
                int kind;
                kind = int'($urandom_range(0, 2));
                q.push_back(mk_op(1'($urandom_range(0, 3) != 0), 1'(kind == 1), 1'(kind == 2),
                                  2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                                  int'($urandom_range(0, 5)), 5'($urandom), 1'($urandom)));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
